univ_shift_reg_param: RTL and testbench

- Parametrised next-generation universal shift register: WIDTH-bit word with hold, logical shifts, rotates, arithmetic shift right and parallel load.
- Adds a self-timed serialise burst: the block loads a word and shifts it out one bit per cycle under a small FSM, with valid/busy/done signalling.
- Used as a datapath register and as a bit-serial transmitter front end.

---
 rtl/univ_shift_reg_param_if.sv | 40 ++++
 rtl/univ_shift_reg_param.sv | 135 +++++++++++++
 tb/tb_univ_shift_reg_param.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/univ_shift_reg_param_if.sv
// Bundle of data/control signals for univ_shift_reg_param.
// The optional shift-amount input exists only when SHREG_SHAMT_EN is defined.
interface univ_shift_reg_param_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = $clog2(WIDTH);

    logic [2:0]       mode;
    logic             MSBin;
    logic             LSBin;
    logic [WIDTH-1:0] Datain;
`ifdef SHREG_SHAMT_EN
    logic [SW-1:0]    shamt;
`endif
    logic [WIDTH-1:0] Dataout;
    logic             MSBout;
    logic             LSBout;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;
    logic [CW-1:0]    bitcnt;

    modport master (
`ifdef SHREG_SHAMT_EN
        output shamt,
`endif
        output mode, MSBin, LSBin, Datain,
        input  Dataout, MSBout, LSBout, sout, sout_valid, busy, done, bitcnt
    );

    modport slave (
`ifdef SHREG_SHAMT_EN
        input  shamt,
`endif
        input  mode, MSBin, LSBin, Datain,
        output Dataout, MSBout, LSBout, sout, sout_valid, busy, done, bitcnt
    );
endinterface

// File: rtl/univ_shift_reg_param.sv
// Universal shift register with a self-timed bit-serial burst; state changes on the falling clk edge.
// Define SHREG_SHAMT_EN to shift/rotate by a variable amount (bus.shamt) instead of 1.
module univ_shift_reg_param #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    univ_shift_reg_param_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONES     = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_next;
    logic [CW-1:0]    r_bitcnt;
    logic [CW-1:0]    w_bitcnt_next;
    logic             r_valid;
    logic             w_valid_next;
    logic             r_done;
    logic             w_done_next;

    logic [SW-1:0]    w_amt;
    logic [WIDTH-1:0] w_hi_mask;
    logic [WIDTH-1:0] w_lo_mask;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_asr;
    logic [WIDTH-1:0] w_burst;

`ifdef SHREG_SHAMT_EN
    assign w_amt = bus.shamt;
`else
    assign w_amt = SW'(1);
`endif

    // Masks select the vacated bit positions so fills replicate to any amount (zero amount = hold).
    assign w_hi_mask = ~(ONES >> w_amt);
    assign w_lo_mask = ~(ONES << w_amt);

    assign w_shr = (r_data >> w_amt) | ({WIDTH{bus.MSBin}} & w_hi_mask);
    assign w_shl = (r_data << w_amt) | ({WIDTH{bus.LSBin}} & w_lo_mask);
    assign w_asr = (r_data >> w_amt) | ({WIDTH{r_data[WIDTH-1]}} & w_hi_mask);
    assign w_ror = (r_data >> w_amt) | (r_data << (WIDTH - int'(w_amt)));
    assign w_rol = (r_data << w_amt) | (r_data >> (WIDTH - int'(w_amt)));

    generate
        if (MSB_FIRST) begin : g_burst_left
            assign w_burst  = {r_data[WIDTH-2:0], 1'b0};
            assign bus.sout = r_data[WIDTH-1];
        end else begin : g_burst_right
            assign w_burst  = {1'b0, r_data[WIDTH-1:1]};
            assign bus.sout = r_data[0];
        end
    endgenerate

    always_ff @(negedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_data   <= '0;
            r_bitcnt <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_data   <= w_data_next;
            r_bitcnt <= w_bitcnt_next;
            r_valid  <= w_valid_next;
            r_done   <= w_done_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_data_next   = r_data;
        w_bitcnt_next = r_bitcnt;
        w_valid_next  = r_valid;
        w_done_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                case (bus.mode)
                    3'd1: w_data_next = w_shr;
                    3'd2: w_data_next = w_shl;
                    3'd3: w_data_next = bus.Datain;
                    3'd4: w_data_next = w_ror;
                    3'd5: w_data_next = w_rol;
                    3'd6: w_data_next = w_asr;
                    3'd7: begin
                        w_data_next   = bus.Datain;
                        w_bitcnt_next = '0;
                        w_valid_next  = 1'b1;
                        w_state_next  = S_SHIFT;
                    end
                    default: ;
                endcase
            end
            S_SHIFT: begin
                w_bitcnt_next = r_bitcnt + CW'(1);
                // The last bit stays on sout until this edge; the word is not shifted again.
                if (r_bitcnt == LAST_BIT) begin
                    w_state_next = S_DONE;
                    w_valid_next = 1'b0;
                    w_done_next  = 1'b1;
                end else begin
                    w_data_next = w_burst;
                end
            end
            S_DONE: begin
                w_bitcnt_next = '0;
                w_state_next  = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign bus.Dataout    = r_data;
    assign bus.MSBout     = r_data[WIDTH-1];
    assign bus.LSBout     = r_data[0];
    assign bus.sout_valid = r_valid;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = r_done;
    assign bus.bitcnt     = r_bitcnt;
endmodule

// File: tb/tb_univ_shift_reg_param.sv
// Directed bench for univ_shift_reg_param: WIDTH=8 LSB-first, WIDTH=4 MSB-first, WIDTH=16.
module tb_univ_shift_reg_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    univ_shift_reg_param_if #(.WIDTH(8))  if8 ();
    univ_shift_reg_param_if #(.WIDTH(4))  if4 ();
    univ_shift_reg_param_if #(.WIDTH(16)) if16 ();

    univ_shift_reg_param #(.WIDTH(8),  .MSB_FIRST(1'b0)) dut8  (.clk(clk), .rst(rst), .bus(if8));
    univ_shift_reg_param #(.WIDTH(4),  .MSB_FIRST(1'b1)) dut4  (.clk(clk), .rst(rst), .bus(if4));
    univ_shift_reg_param #(.WIDTH(16), .MSB_FIRST(1'b0)) dut16 (.clk(clk), .rst(rst), .bus(if16));

    typedef struct {
        string      name;
        logic [2:0] mode;
        logic       msbin;
        logic       lsbin;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [7];

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] burst8;
        logic [3:0] burst4;
        bit         saw_done;

        vecs[0] = '{"load_a5", 3'd3, 1'b0, 1'b0, 8'hA5, 8'hA5};
        vecs[1] = '{"shr",     3'd1, 1'b1, 1'b0, 8'h00, 8'hDA};
        vecs[2] = '{"shl",     3'd2, 1'b0, 1'b1, 8'h00, 8'h69};
        vecs[3] = '{"ror",     3'd4, 1'b0, 1'b0, 8'h00, 8'h5A};
        vecs[4] = '{"rol",     3'd5, 1'b0, 1'b0, 8'h00, 8'h69};
        vecs[5] = '{"asr",     3'd6, 1'b0, 1'b0, 8'h00, 8'hDA};
        vecs[6] = '{"hold",    3'd0, 1'b1, 1'b1, 8'hFF, 8'hB4};

        if8.mode = 3'd0;  if8.MSBin = 1'b0;  if8.LSBin = 1'b0;  if8.Datain = '0;
        if4.mode = 3'd0;  if4.MSBin = 1'b0;  if4.LSBin = 1'b0;  if4.Datain = '0;
        if16.mode = 3'd0; if16.MSBin = 1'b0; if16.LSBin = 1'b0; if16.Datain = '0;
`ifdef SHREG_SHAMT_EN
        if8.shamt = 3'd1; if4.shamt = 2'd1; if16.shamt = 4'd1;
`endif
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        chk("rst_dataout", if8.Dataout, 8'h00);
        chk("rst_busy", if8.busy, 1'b0);
        chk("rst_bitcnt", if8.bitcnt, 4'd0);

        // Reset after a load
        if8.mode = 3'd3; if8.Datain = 8'hA5;
        step();
        chk("load_a5", if8.Dataout, 8'hA5);
        if8.mode = 3'd0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        $display("txn reset_after_load dataout=%h busy=%b done=%b", if8.Dataout, if8.busy, if8.done);
        chk("rst2_dataout", if8.Dataout, 8'h00);
        chk("rst2_busy", if8.busy, 1'b0);
        chk("rst2_done", if8.done, 1'b0);

        // Table-driven mode checks, each from a fresh 8'hB4
        for (int i = 0; i < 7; i++) begin
            if8.mode = 3'd3; if8.Datain = 8'hB4;
            step();
            if8.mode = vecs[i].mode; if8.MSBin = vecs[i].msbin;
            if8.LSBin = vecs[i].lsbin; if8.Datain = vecs[i].din;
            step();
            $display("txn %s mode=%0d dataout=%h expect=%h", vecs[i].name, vecs[i].mode, if8.Dataout, vecs[i].exp);
            chk(vecs[i].name, if8.Dataout, vecs[i].exp);
            chk({vecs[i].name, "_msbout"}, if8.MSBout, vecs[i].exp[7]);
            chk({vecs[i].name, "_lsbout"}, if8.LSBout, vecs[i].exp[0]);
        end
        if8.mode = 3'd0; if8.MSBin = 1'b0; if8.LSBin = 1'b0;
        step();

        // LSB-first burst of 8'hC3; a second start mid-burst must be dropped
        burst8 = 8'b1100_0011;
        if8.mode = 3'd7; if8.Datain = 8'hC3;
        step();
        if8.Datain = 8'h00;
        for (int i = 0; i < 8; i++) begin
            $display("txn burst8 bit=%0d sout=%b valid=%b", i, if8.sout, if8.sout_valid);
            chk("b8_valid", if8.sout_valid, 1'b1);
            chk("b8_sout", if8.sout, burst8[i]);
            chk("b8_busy", if8.busy, 1'b1);
            chk("b8_done", if8.done, 1'b0);
            chk("b8_bitcnt", if8.bitcnt, i);
            if8.mode = (i == 2) ? 3'd7 : 3'd0;
            step();
        end
        $display("txn burst8_done dataout=%h done=%b", if8.Dataout, if8.done);
        chk("b8_done_pulse", if8.done, 1'b1);
        chk("b8_done_valid", if8.sout_valid, 1'b0);
        chk("b8_done_busy", if8.busy, 1'b1);
        chk("b8_final", if8.Dataout, 8'h01);
        step();
        chk("b8_idle_done", if8.done, 1'b0);
        chk("b8_idle_busy", if8.busy, 1'b0);
        chk("b8_idle_bitcnt", if8.bitcnt, 4'd0);
        chk("b8_idle_data", if8.Dataout, 8'h01);

        // Reset in the middle of a burst at bitcnt=3
        if8.mode = 3'd7; if8.Datain = 8'hFF;
        step();
        if8.mode = 3'd0;
        for (int i = 0; i < 3; i++) step();
        chk("abort_bitcnt", if8.bitcnt, 4'd3);
        rst = 1'b0;
        step();
        rst = 1'b1;
        $display("txn burst_abort dataout=%h busy=%b valid=%b", if8.Dataout, if8.busy, if8.sout_valid);
        chk("abort_busy", if8.busy, 1'b0);
        chk("abort_valid", if8.sout_valid, 1'b0);
        chk("abort_data", if8.Dataout, 8'h00);
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (if8.done) saw_done = 1'b1;
            step();
        end
        chk("abort_no_done", saw_done, 1'b0);
        chk("abort_stay_idle", if8.busy, 1'b0);

        // MSB-first burst, WIDTH=4; a mid-burst load must be ignored
        burst4 = 4'b1001;
        if4.mode = 3'd7; if4.Datain = 4'h9;
        step();
        if4.mode = 3'd0;
        for (int i = 0; i < 4; i++) begin
            $display("txn burst4 bit=%0d sout=%b valid=%b", i, if4.sout, if4.sout_valid);
            chk("b4_valid", if4.sout_valid, 1'b1);
            chk("b4_sout", if4.sout, burst4[3-i]);
            if (i == 1) begin
                if4.mode = 3'd3; if4.Datain = 4'hF;
            end else begin
                if4.mode = 3'd0;
            end
            step();
        end
        chk("b4_done_pulse", if4.done, 1'b1);
        chk("b4_final", if4.Dataout, 4'h8);
        if4.mode = 3'd0;
        step();
        chk("b4_idle_busy", if4.busy, 1'b0);

        // WIDTH=16 sweep
        if16.mode = 3'd3; if16.Datain = 16'h8001;
        step();
        if16.mode = 3'd6;
        step();
        $display("txn w16_asr dataout=%h", if16.Dataout);
        chk("w16_asr", if16.Dataout, 16'hC000);
        if16.mode = 3'd3;
        step();
        if16.mode = 3'd5;
        step();
        $display("txn w16_rol dataout=%h", if16.Dataout);
        chk("w16_rol", if16.Dataout, 16'h0003);
        if16.mode = 3'd0;

`ifdef SHREG_SHAMT_EN
        if8.mode = 3'd3; if8.Datain = 8'h81;
        step();
        if8.mode = 3'd1; if8.MSBin = 1'b1; if8.shamt = 3'd3;
        step();
        $display("txn shamt_shr dataout=%h", if8.Dataout);
        chk("shamt_shr3", if8.Dataout, 8'hF0);
        if8.mode = 3'd4; if8.shamt = 3'd0;
        step();
        $display("txn shamt_ror0 dataout=%h", if8.Dataout);
        chk("shamt_ror0", if8.Dataout, 8'hF0);
        if8.mode = 3'd0; if8.shamt = 3'd1;
`endif

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
